data_demux: RTL and testbench
=============================

DATA_DEMUX -- requirements
Module: data_demux

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning data width in bits.
REQ-002 The module SHALL have parameter DEPTH, default 2, meaning entries per channel buffer (power of two, >=2).
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have port in_valid, input, 1 bit: the upstream word is valid.
REQ-006 The module SHALL have port in_ready, output, 1 bit: the block accepts the current word.
REQ-007 The module SHALL have port sel, input, 2 bits: destination channel 0..3, qualified by in_valid.
REQ-008 The module SHALL have port in_data, input, WIDTH bits: upstream word.
REQ-009 The module SHALL have port out_valid, output, 4 bits: bit i means channel i holds a word.
REQ-010 The module SHALL have port out_ready, input, 4 bits: bit i means the channel i consumer takes the head word.
REQ-011 The module SHALL have ports out0, out1, out2, out3, output, WIDTH bits each: channel head words.
REQ-012 The module SHALL have port occ, output, 4x2 bits packed as 8 bits, bits [2i+1:2i] = channel i occupancy (0..DEPTH).

Function
REQ-013 The block SHALL accept a word (push) at a rising edge when in_valid=1 and in_ready=1.
REQ-014 A push SHALL write in_data into the FIFO of channel sel.
REQ-015 in_ready SHALL be 1 iff rst=0 and the channel addressed by sel is not full; it SHALL have no combinational dependence on out_ready.
REQ-016 out_valid[i] SHALL be 1 iff channel i occupancy > 0.
REQ-017 out_i SHALL present the oldest word of channel i, and SHALL be 0 when channel i is empty.
REQ-018 A pop of channel i SHALL occur at a rising edge when out_valid[i]=1 and out_ready[i]=1.
REQ-019 Latency: a word pushed at edge N SHALL be visible on out_i with out_valid[i]=1 immediately after edge N, i.e. one cycle, with no combinational bypass.
REQ-020 Each channel SHALL preserve FIFO order; channels SHALL be fully independent, so a full or stalled channel never blocks pushes to other channels.
REQ-021 Simultaneous push and pop on the same non-full, non-empty channel SHALL leave its occupancy unchanged and keep the order.
REQ-022 A push to an empty channel with out_ready[i]=1 SHALL NOT pop in the same edge.
REQ-023 A full channel SHALL refuse a push even while it pops in that edge; in_ready rises the cycle after the pop.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH; occ SHALL never exceed DEPTH or underflow.
REQ-025 out_ready[i]=1 while channel i is empty SHALL have no effect.
REQ-026 in_valid=0 SHALL cause no state change regardless of sel and in_data.

Reset
REQ-027 While rst=1 at an edge, all channel FIFOs SHALL become empty: pointers 0, occ=0, out_valid=0, out0..out3=0.
REQ-028 in_ready SHALL be 0 while rst=1.
REQ-029 Reset mid-operation SHALL discard all buffered words, and a push presented in the reset cycle SHALL be dropped.

Structure
REQ-030 Package data_demux_pkg SHALL hold WIDTH, DEPTH, NCH=4, the channel-index type and the occupancy type.
REQ-031 A sub-module demux_chan_fifo (single-channel DEPTH-entry FIFO with push, pop, full, empty, occ and head outputs) SHALL be instantiated once per channel.
REQ-032 The top level SHALL contain only the sel decode, the in_ready mux and the output packing.

Verification
REQ-033 Routing: push AA->ch0, 55->ch1, 23->ch2, 78->ch3 with all out_ready=0 -> out0..out3 = AA,55,23,78; out_valid=4'b1111; occ=8'h55.
REQ-034 Full/backpressure: push 11, 22, 33 to ch1 with out_ready=0 -> the third word is held off (in_ready=0, occ ch1=2); then pulse out_ready[1] for one edge -> out1=22, and in_ready returns to 1 the next cycle.
REQ-035 Independence: with ch1 full, push 44->ch2 -> accepted the same cycle; out2=44.
REQ-036 Concurrent: ch0 holds 01; push 02->ch0 with out_ready[0]=1 -> occ ch0 stays 1 and out0=02 after the edge.
REQ-037 Reset mid-stream: with all channels non-empty, assert rst for one cycle -> out_valid=0, occ=0, out0..out3=0, in_ready=0 during rst.
REQ-038 Wrap: on ch3, run 6 alternating push/pop pairs with data 0..5 -> outputs appear in order 0..5 and no word is lost or duplicated.

Source files
------------

// File: rtl/data_demux_pkg.sv
// Shared sizing constants and small types for the four-channel data demultiplexer.
package data_demux_pkg;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 2;
   localparam int unsigned NCH   = 4;

   typedef logic [1:0] chan_idx_t;
   typedef logic [1:0] occ_t;

endpackage

// File: rtl/demux_chan_fifo.sv
// Single-channel FIFO of DEPTH entries; the head word reads as zero while the FIFO is empty.
module demux_chan_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 2,
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] occ,
   output logic [WIDTH-1:0] head
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
   logic [CNT_W-1:0] cnt_q;
   logic             do_push, do_pop;

   assign full  = (cnt_q == CNT_W'(DEPTH));
   assign empty = (cnt_q == '0);
   assign occ   = cnt_q;

   // Fullness and emptiness come from registered state, so a full FIFO refuses a push even
   // while popping, and a push into an empty FIFO cannot be popped in the same edge.
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   assign head = empty ? '0 : mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         unique case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + CNT_W'(1);
            2'b01:   cnt_q <= cnt_q - CNT_W'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Storage needs no reset: the head is masked to zero whenever the count is zero.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/data_demux.sv
// Routes each accepted upstream word into one of four independent per-channel FIFOs by sel.
module data_demux #(
   parameter int unsigned WIDTH = data_demux_pkg::WIDTH,
   parameter int unsigned DEPTH = data_demux_pkg::DEPTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       sel,
   input  logic [WIDTH-1:0] in_data,
   output logic [3:0]       out_valid,
   input  logic [3:0]       out_ready,
   output logic [WIDTH-1:0] out0,
   output logic [WIDTH-1:0] out1,
   output logic [WIDTH-1:0] out2,
   output logic [WIDTH-1:0] out3,
   output logic [7:0]       occ
);

   import data_demux_pkg::*;

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   chan_idx_t        ch;
   logic [NCH-1:0]   push, full, empty;
   logic [CNT_W-1:0] chan_occ [NCH];
   logic [WIDTH-1:0] head [NCH];

   assign ch       = sel;
   assign in_ready = ~rst & ~full[ch];

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      assign push[i] = in_valid & in_ready & (ch == chan_idx_t'(i));

      demux_chan_fifo #(
         .WIDTH (WIDTH),
         .DEPTH (DEPTH)
      ) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .push  (push[i]),
         .wdata (in_data),
         .pop   (out_ready[i]),
         .full  (full[i]),
         .empty (empty[i]),
         .occ   (chan_occ[i]),
         .head  (head[i])
      );

      assign out_valid[i]  = ~empty[i];
      assign occ[2*i +: 2] = occ_t'(chan_occ[i]);
   end

   assign out0 = head[0];
   assign out1 = head[1];
   assign out2 = head[2];
   assign out3 = head[3];

endmodule

// File: tb/tb_data_demux.sv
// Directed bench for data_demux: a vector table checked before each edge, plus wrap/stream runs.
module tb_data_demux;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] sel;
   logic [7:0] in_data;
   logic [3:0] out_valid;
   logic [3:0] out_ready;
   logic [7:0] out0, out1, out2, out3;
   logic [7:0] occ;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   data_demux dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sel       (sel),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out0      (out0),
      .out1      (out1),
      .out2      (out2),
      .out3      (out3),
      .occ       (occ)
   );

   // Expectations describe outputs just before the edge at which the inputs are sampled.
   typedef struct {
      string       name;
      logic        r;
      logic        iv;
      logic [1:0]  s;
      logic [7:0]  d;
      logic [3:0]  ordy;
      logic        e_rdy;
      logic [3:0]  e_ov;
      logic [7:0]  e_occ;
      logic [31:0] e_outs;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input string name, input logic r, input logic iv, input logic [1:0] s,
                      input logic [7:0] d, input logic [3:0] ordy, input logic e_rdy,
                      input logic [3:0] e_ov, input logic [7:0] e_occ, input logic [31:0] e_outs);
      vec_t v;
      v.name = name; v.r = r; v.iv = iv; v.s = s; v.d = d; v.ordy = ordy;
      v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_occ = e_occ; v.e_outs = e_outs;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic iv, input logic [1:0] s, input logic [7:0] d,
                        input logic [3:0] ordy);
      rst = r; in_valid = iv; sel = s; in_data = d; out_ready = ordy;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] q[$];
      logic       do_push;
      logic       acc;

      //   name         rst iv sel data   ordy     rdy  ov       occ    {out3,out2,out1,out0}
      add("reset",      1, 1, 0, 8'hFF, 4'b0000, 0, 4'b0000, 8'h00, 32'h00000000);
      add("rst_drop",   0, 0, 0, 8'h00, 4'b1111, 1, 4'b0000, 8'h00, 32'h00000000);
      add("route0",     0, 1, 0, 8'hAA, 4'b0000, 1, 4'b0000, 8'h00, 32'h00000000);
      add("route1",     0, 1, 1, 8'h55, 4'b0000, 1, 4'b0001, 8'h01, 32'h000000AA);
      add("route2",     0, 1, 2, 8'h23, 4'b0000, 1, 4'b0011, 8'h05, 32'h000055AA);
      add("route3",     0, 1, 3, 8'h78, 4'b0000, 1, 4'b0111, 8'h15, 32'h002355AA);
      add("routed",     0, 0, 2, 8'hEE, 4'b0000, 1, 4'b1111, 8'h55, 32'h782355AA);
      add("idle_nop",   0, 0, 0, 8'h00, 4'b1111, 1, 4'b1111, 8'h55, 32'h782355AA);
      add("fill1",      0, 1, 1, 8'h11, 4'b0000, 1, 4'b0000, 8'h00, 32'h00000000);
      add("fill2",      0, 1, 1, 8'h22, 4'b0000, 1, 4'b0010, 8'h04, 32'h00001100);
      add("full_hold",  0, 1, 1, 8'h33, 4'b0000, 0, 4'b0010, 8'h08, 32'h00001100);
      add("full_pop",   0, 1, 1, 8'h33, 4'b0010, 0, 4'b0010, 8'h08, 32'h00001100);
      add("ready_back", 0, 1, 1, 8'h33, 4'b0000, 1, 4'b0010, 8'h04, 32'h00002200);
      add("indep",      0, 1, 2, 8'h44, 4'b0000, 1, 4'b0010, 8'h08, 32'h00002200);
      add("full_again", 0, 1, 1, 8'h99, 4'b0000, 0, 4'b0110, 8'h18, 32'h00442200);
      add("conc_pre",   0, 1, 0, 8'h01, 4'b0000, 1, 4'b0110, 8'h18, 32'h00442200);
      add("conc",       0, 1, 0, 8'h02, 4'b0001, 1, 4'b0111, 8'h19, 32'h00442201);
      add("empty_pp",   0, 1, 3, 8'h5A, 4'b1000, 1, 4'b0111, 8'h19, 32'h00442202);
      add("all_busy",   0, 0, 0, 8'h00, 4'b0000, 1, 4'b1111, 8'h59, 32'h5A442202);
      add("mid_rst",    1, 1, 3, 8'h77, 4'b0000, 0, 4'b1111, 8'h59, 32'h5A442202);
      add("post_rst",   0, 0, 0, 8'h00, 4'b0000, 1, 4'b0000, 8'h00, 32'h00000000);

      drive(1, 0, 0, 8'h00, 4'b0000);
      repeat (2) @(posedge clk);

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].r, vecs[i].iv, vecs[i].s, vecs[i].d, vecs[i].ordy);
         #2;
         chk({vecs[i].name, ".in_ready"},  {31'd0, in_ready},   {31'd0, vecs[i].e_rdy});
         chk({vecs[i].name, ".out_valid"}, {28'd0, out_valid},  {28'd0, vecs[i].e_ov});
         chk({vecs[i].name, ".occ"},       {24'd0, occ},        {24'd0, vecs[i].e_occ});
         chk({vecs[i].name, ".outs"},      {out3, out2, out1, out0}, vecs[i].e_outs);
      end

      // Alternating push/pop on ch3: pointers wrap three times over six words.
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         drive(0, 1, 3, 8'(k), 4'b0000);
         #2;
         chk("wrap.in_ready", {31'd0, in_ready}, 32'd1);
         @(negedge clk);
         drive(0, 0, 0, 8'h00, 4'b1000);
         #2;
         chk("wrap.out3", {24'd0, out3}, k);
         chk("wrap.occ3", {30'd0, occ[7:6]}, 32'd1);
      end
      @(negedge clk);
      drive(0, 0, 0, 8'h00, 4'b0000);
      #2;
      chk("wrap.drained_ov", {28'd0, out_valid}, 32'd0);
      chk("wrap.drained_occ", {24'd0, occ}, 32'd0);

      // Continuous push with out_ready[3] held high, checked against a queue model.
      for (int c = 0; c < 9; c++) begin
         do_push = (c < 6);
         @(negedge clk);
         drive(0, do_push, 3, 8'(8'h10 + c), 4'b1000);
         #2;
         chk("stream.in_ready", {31'd0, in_ready}, {31'd0, (q.size() < 2)});
         chk("stream.ov3", {31'd0, out_valid[3]}, {31'd0, (q.size() > 0)});
         chk("stream.out3", {24'd0, out3}, (q.size() > 0) ? {24'd0, q[0]} : 32'd0);
         acc = do_push && (q.size() < 2);
         if (q.size() > 0) void'(q.pop_front());
         if (acc) q.push_back(8'(8'h10 + c));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
